// File: rtl/kernel_bc_fifo_pkg.sv
// rtl/kernel_bc_fifo_pkg.sv - shared constants and helpers for the broadcast start FIFO
//
// Purpose: default geometry, occupancy-width helper and the max reduction
//          used to build occ_max from the per-consumer counters.
// Ports:   none (package).
package kernel_bc_fifo_pkg;

  localparam int DEFAULT_DEPTH      = 4;
  localparam int DEFAULT_ADDR_WIDTH = 2;

  // Working width for the max reduction; wide enough for any legal counter.
  localparam int OCC_CALC_W = 16;

  // Bits needed to hold the values 0..n inclusive.
  function automatic int clog2p1(input int n);
    return $clog2(n + 1);
  endfunction

  function automatic logic [OCC_CALC_W-1:0] max_occ(
    input logic [OCC_CALC_W-1:0] a,
    input logic [OCC_CALC_W-1:0] b
  );
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kernel_bc_start_fork_fifo_shiftReg.sv
// rtl/kernel_bc_start_fork_fifo_shiftReg.sv - shared shift-register storage with per-consumer read taps
//
// Purpose: DEPTH-entry shift register; one shift enable, NUM_CONS
//          independent combinational read addresses.
// Ports:   clk  - clock
//          ce   - shift enable (accepted write)
//          data - word shifted into entry 0
//          addr - per-consumer read address, consumer c at [c*ADDR_WIDTH +: ADDR_WIDTH]
//          q    - per-consumer read data, consumer c at [c*DATA_WIDTH +: DATA_WIDTH]
module kernel_bc_start_fork_fifo_shiftReg #(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = 2,
  parameter int DEPTH      = 4,
  parameter int NUM_CONS   = 2
) (
  input  logic                           clk,
  input  logic                           ce,
  input  logic [DATA_WIDTH-1:0]          data,
  input  logic [NUM_CONS*ADDR_WIDTH-1:0] addr,
  output logic [NUM_CONS*DATA_WIDTH-1:0] q
);

  // Contents are deliberately not reset; validity is tracked by the counters.
  logic [DATA_WIDTH-1:0] srl [DEPTH];

  always_ff @(posedge clk) begin
    if (ce) begin
      srl[0] <= data;
      for (int i = 1; i < DEPTH; i++) begin
        srl[i] <= srl[i-1];
      end
    end
  end

  for (genvar c = 0; c < NUM_CONS; c++) begin : g_tap
    assign q[c*DATA_WIDTH +: DATA_WIDTH] = srl[addr[c*ADDR_WIDTH +: ADDR_WIDTH]];
  end

endmodule

// File: rtl/kernel_bc_start_fork_fifo.sv
// rtl/kernel_bc_start_fork_fifo.sv - one-producer, NUM_CONS-consumer broadcast start FIFO
//
// Purpose: every written word is delivered once to each consumer; an entry
//          leaves the shared storage only after the slowest consumer read it.
//          Outputs are first-word-fall-through, flags are registered.
// Ports:   clk, reset          - clock, synchronous active-high reset
//          if_din, if_write,
//          if_write_ce         - write side; request is if_write & if_write_ce
//          if_full_n           - 1 when every consumer has space
//          if_read, if_read_ce - per-consumer read request, shared read enable
//          if_empty_n          - per-consumer data valid
//          if_dout             - consumer c on [c*DATA_WIDTH +: DATA_WIDTH]
//          occ_max             - registered max occupancy over all consumers
//          peak_clr, peak_occ  - sticky peak of occ_max and its clear, only
//                                with KERNEL_BC_START_FORK_PEAK_EN defined
module kernel_bc_start_fork_fifo
  import kernel_bc_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 1,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int DEPTH      = DEFAULT_DEPTH,
  parameter int NUM_CONS   = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [DATA_WIDTH-1:0]          if_din,
  input  logic                           if_write,
  input  logic                           if_write_ce,
  output logic                           if_full_n,
  input  logic [NUM_CONS-1:0]            if_read,
  input  logic                           if_read_ce,
  output logic [NUM_CONS-1:0]            if_empty_n,
  output logic [NUM_CONS*DATA_WIDTH-1:0] if_dout,
  output logic [ADDR_WIDTH:0]            occ_max
`ifdef KERNEL_BC_START_FORK_PEAK_EN
  ,
  input  logic                           peak_clr,
  output logic [ADDR_WIDTH:0]            peak_occ
`endif
);

  localparam int OW = ADDR_WIDTH + 1;
  localparam logic [OW-1:0] DEPTH_V = OW'(DEPTH);
  localparam logic [OW-1:0] ONE     = OW'(1);

  // Power-up values equal the reset values.
  logic [NUM_CONS*OW-1:0] occ_q     = '0;
  logic [NUM_CONS-1:0]    empty_n_q = '0;
  logic                   full_n_q  = 1'b1;
  logic [OW-1:0]          max_q     = '0;

  logic [NUM_CONS*OW-1:0]         occ_nxt;
  logic [NUM_CONS-1:0]            empty_nxt;
  logic [NUM_CONS-1:0]            rd_accept;
  logic [NUM_CONS*ADDR_WIDTH-1:0] rd_addr;
  logic                           wr_accept;
  logic                           full_nxt;
  logic [OW-1:0]                  max_nxt;

  assign if_full_n  = full_n_q;
  assign if_empty_n = empty_n_q;
  assign occ_max    = max_q;

  // Gating on the registered full flag is what rejects a write arriving
  // together with a read on a full FIFO.
  assign wr_accept = if_write & if_write_ce & full_n_q;

  for (genvar c = 0; c < NUM_CONS; c++) begin : g_cons
    logic [OW-1:0] cur;
    logic [OW-1:0] nxt;

    assign cur          = occ_q[c*OW +: OW];
    assign rd_accept[c] = if_read[c] & if_read_ce & empty_n_q[c];

    // Write and read together cancel out.
    assign nxt = (wr_accept == rd_accept[c]) ? cur :
                 (wr_accept ? cur + ONE : cur - ONE);

    assign occ_nxt[c*OW +: OW] = nxt;
    assign empty_nxt[c]        = (nxt != '0);

    // Oldest unread word for this consumer sits occ-1 places down the chain.
    assign rd_addr[c*ADDR_WIDTH +: ADDR_WIDTH] =
      (cur == '0) ? '0 : ADDR_WIDTH'(cur - ONE);
  end

  always_comb begin
    logic [OCC_CALC_W-1:0] acc;
    full_nxt = 1'b1;
    acc      = '0;
    for (int i = 0; i < NUM_CONS; i++) begin
      if (occ_nxt[i*OW +: OW] >= DEPTH_V) begin
        full_nxt = 1'b0;
      end
      acc = max_occ(acc, OCC_CALC_W'(occ_nxt[i*OW +: OW]));
    end
    max_nxt = OW'(acc);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q     <= '0;
      empty_n_q <= '0;
      full_n_q  <= 1'b1;
      max_q     <= '0;
    end else begin
      occ_q     <= occ_nxt;
      empty_n_q <= empty_nxt;
      full_n_q  <= full_nxt;
      max_q     <= max_nxt;
    end
  end

  kernel_bc_start_fork_fifo_shiftReg #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .NUM_CONS   (NUM_CONS)
  ) u_srl (
    .clk  (clk),
    .ce   (wr_accept),
    .data (if_din),
    .addr (rd_addr),
    .q    (if_dout)
  );

`ifdef KERNEL_BC_START_FORK_PEAK_EN
  logic [OW-1:0] peak_q = '0;

  // Tracks the value occ_max takes on the same edge, so peak never lags it.
  always_ff @(posedge clk) begin
    if (reset || peak_clr) begin
      peak_q <= '0;
    end else if (max_nxt > peak_q) begin
      peak_q <= max_nxt;
    end
  end

  assign peak_occ = peak_q;
`endif

endmodule

// File: tb/tb_kernel_bc_start_fork_fifo.sv
// tb/tb_kernel_bc_start_fork_fifo.sv - self-checking bench for kernel_bc_start_fork_fifo
module tb_kernel_bc_start_fork_fifo;

  localparam int DW    = 4;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int NC    = 2;
  localparam int OW    = AW + 1;

  logic              clk         = 1'b0;
  logic              reset       = 1'b1;
  logic [DW-1:0]     if_din      = '0;
  logic              if_write    = 1'b0;
  logic              if_write_ce = 1'b1;
  logic [NC-1:0]     if_read     = '0;
  logic              if_read_ce  = 1'b1;
  logic              if_full_n;
  logic [NC-1:0]     if_empty_n;
  logic [NC*DW-1:0]  if_dout;
  logic [OW-1:0]     occ_max;
`ifdef KERNEL_BC_START_FORK_PEAK_EN
  logic              peak_clr    = 1'b0;
  logic [OW-1:0]     peak_occ;
`endif

  int total = 0;
  int bad   = 0;

  // Reference: each consumer sees its own queue of undelivered words.
  logic [DW-1:0] mq [NC][$];
  int peak_m = 0;

  always #5 clk = ~clk;

  kernel_bc_start_fork_fifo #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .NUM_CONS   (NC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .if_din      (if_din),
    .if_write    (if_write),
    .if_write_ce (if_write_ce),
    .if_full_n   (if_full_n),
    .if_read     (if_read),
    .if_read_ce  (if_read_ce),
    .if_empty_n  (if_empty_n),
    .if_dout     (if_dout),
    .occ_max     (occ_max)
`ifdef KERNEL_BC_START_FORK_PEAK_EN
    ,
    .peak_clr    (peak_clr),
    .peak_occ    (peak_occ)
`endif
  );

  typedef struct {
    logic          wr;
    logic          wce;
    logic [DW-1:0] din;
    logic [NC-1:0] rd;
    logic          rce;
    logic [NC-1:0] e_empty;
    logic          e_full;
    logic [OW-1:0] e_max;
    logic [NC-1:0] e_dmask;
    logic [NC*DW-1:0] e_dout;
  } vec_t;

  vec_t vt [8];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int mmax();
    int m = 0;
    for (int c = 0; c < NC; c++) if (mq[c].size() > m) m = mq[c].size();
    return m;
  endfunction

  function automatic int mfull_n();
    int f = 1;
    for (int c = 0; c < NC; c++) if (mq[c].size() >= DEPTH) f = 0;
    return f;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) mq[c].delete();
    peak_m = 0;
  endtask

  task automatic model_clock(input logic wr, input logic wce, input logic [DW-1:0] din,
                             input logic [NC-1:0] rd, input logic rce, input logic clr);
    logic w;
    logic [NC-1:0] r;
    w = wr & wce & (mfull_n() == 1);
    for (int c = 0; c < NC; c++) r[c] = rd[c] & rce & (mq[c].size() != 0);
    for (int c = 0; c < NC; c++) begin
      if (r[c]) mq[c].delete(0);
      if (w) mq[c].push_back(din);
    end
    if (clr) peak_m = 0;
    else if (mmax() > peak_m) peak_m = mmax();
  endtask

  task automatic check_model(input string tag);
    for (int c = 0; c < NC; c++) begin
      chk({tag, "_empty_n"}, int'(if_empty_n[c]), int'(mq[c].size() != 0));
      if (mq[c].size() != 0) chk({tag, "_dout"}, int'(if_dout[c*DW +: DW]), int'(mq[c][0]));
    end
    chk({tag, "_full_n"}, int'(if_full_n), mfull_n());
    chk({tag, "_occ_max"}, int'(occ_max), mmax());
    chk({tag, "_occ_bound"}, int'(occ_max <= OW'(DEPTH)), 1);
`ifdef KERNEL_BC_START_FORK_PEAK_EN
    chk({tag, "_peak"}, int'(peak_occ), peak_m);
`endif
  endtask

  task automatic step(input logic wr, input logic wce, input logic [DW-1:0] din,
                      input logic [NC-1:0] rd, input logic rce, input logic clr,
                      input string tag);
    if_write    = wr;
    if_write_ce = wce;
    if_din      = din;
    if_read     = rd;
    if_read_ce  = rce;
`ifdef KERNEL_BC_START_FORK_PEAK_EN
    peak_clr    = clr;
`endif
    @(posedge clk);
    model_clock(wr, wce, din, rd, rce, clr);
    #1;
    check_model(tag);
  endtask

  task automatic do_reset(input logic wr_during);
    reset    = 1'b1;
    if_write = wr_during;
    if_din   = 4'hF;
    if_read  = '1;
    @(posedge clk);
    model_reset();
    #1;
    reset    = 1'b0;
    if_write = 1'b0;
    if_read  = '0;
  endtask

  initial begin
    vt[0] = '{1'b1, 1'b1, 4'hA, 2'b00, 1'b1, 2'b11, 1'b1, 3'd1, 2'b11, 8'hAA};
    vt[1] = '{1'b1, 1'b1, 4'hB, 2'b00, 1'b1, 2'b11, 1'b1, 3'd2, 2'b11, 8'hAA};
    vt[2] = '{1'b0, 1'b1, 4'h0, 2'b11, 1'b1, 2'b11, 1'b1, 3'd1, 2'b11, 8'hBB};
    vt[3] = '{1'b0, 1'b1, 4'h0, 2'b11, 1'b1, 2'b00, 1'b1, 3'd0, 2'b00, 8'h00};
    vt[4] = '{1'b0, 1'b1, 4'h0, 2'b11, 1'b1, 2'b00, 1'b1, 3'd0, 2'b00, 8'h00};
    vt[5] = '{1'b1, 1'b1, 4'hC, 2'b11, 1'b0, 2'b11, 1'b1, 3'd1, 2'b11, 8'hCC};
    vt[6] = '{1'b1, 1'b0, 4'hD, 2'b01, 1'b1, 2'b10, 1'b1, 3'd1, 2'b10, 8'hC0};
    vt[7] = '{1'b0, 1'b1, 4'h0, 2'b10, 1'b1, 2'b00, 1'b1, 3'd0, 2'b00, 8'h00};

    @(posedge clk);
    do_reset(1'b0);
    chk("reset_empty_n", int'(if_empty_n), 0);
    chk("reset_full_n", int'(if_full_n), 1);
    chk("reset_occ_max", int'(occ_max), 0);

    // Basic write/read vectors.
    for (int i = 0; i < 8; i++) begin
      step(vt[i].wr, vt[i].wce, vt[i].din, vt[i].rd, vt[i].rce, 1'b0, "vec");
      chk($sformatf("vec%0d_empty_n", i), int'(if_empty_n), int'(vt[i].e_empty));
      chk($sformatf("vec%0d_full_n", i), int'(if_full_n), int'(vt[i].e_full));
      chk($sformatf("vec%0d_occ_max", i), int'(occ_max), int'(vt[i].e_max));
      for (int c = 0; c < NC; c++)
        if (vt[i].e_dmask[c])
          chk($sformatf("vec%0d_dout%0d", i, c), int'(if_dout[c*DW +: DW]),
              int'(vt[i].e_dout[c*DW +: DW]));
    end

    // Slow consumer back-pressure.
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'(i + 1), 2'b01, 1'b1, 1'b0, "slow_fill");
    chk("slow_full_after4", int'(if_full_n), 0);
    step(1'b1, 1'b1, 4'd5, 2'b01, 1'b1, 1'b0, "slow_hold");
    chk("slow_c0_drained", int'(if_empty_n[0]), 0);
    chk("slow_still_full", int'(if_full_n), 0);
    step(1'b1, 1'b1, 4'd5, 2'b10, 1'b1, 1'b0, "slow_c1_read");
    chk("slow_full_rise", int'(if_full_n), 1);
    chk("slow_w5_not_yet", int'(if_empty_n[0]), 0);
    step(1'b1, 1'b1, 4'd5, 2'b00, 1'b1, 1'b0, "slow_accept");
    chk("slow_w5_dout0", int'(if_dout[3:0]), 5);
    chk("slow_w5_max", int'(occ_max), 4);

    // Full with simultaneous read and write: only the read lands.
    step(1'b1, 1'b1, 4'd6, 2'b11, 1'b1, 1'b0, "full_rw");
    chk("full_rw_max", int'(occ_max), 3);
    chk("full_rw_dout1", int'(if_dout[7:4]), 3);
    chk("full_rw_full_n", int'(if_full_n), 1);
    step(1'b1, 1'b1, 4'd6, 2'b00, 1'b1, 1'b0, "full_next_w");
    chk("full_next_dout0", int'(if_dout[3:0]), 6);
    chk("full_next_full_n", int'(if_full_n), 0);

    // Streaming read+write at occupancy 2.
    do_reset(1'b0);
    step(1'b1, 1'b1, 4'd7, 2'b00, 1'b1, 1'b0, "rw2_fill");
    step(1'b1, 1'b1, 4'd8, 2'b00, 1'b1, 1'b0, "rw2_fill");
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, 4'(9 + i), 2'b11, 1'b1, 1'b0, "rw2");
      chk("rw2_max", int'(occ_max), 2);
      chk("rw2_dout0", int'(if_dout[3:0]), 8 + i);
      chk("rw2_dout1", int'(if_dout[7:4]), 8 + i);
    end

    // Reset in the middle of traffic with occ={3,1}.
    do_reset(1'b0);
    step(1'b1, 1'b1, 4'd1, 2'b00, 1'b1, 1'b0, "mid_fill");
    step(1'b1, 1'b1, 4'd2, 2'b10, 1'b1, 1'b0, "mid_fill");
    step(1'b1, 1'b1, 4'd3, 2'b10, 1'b1, 1'b0, "mid_fill");
    chk("mid_occ_max", int'(occ_max), 3);
    chk("mid_empty_n", int'(if_empty_n), 3);
    do_reset(1'b1);
    chk("mid_rst_empty_n", int'(if_empty_n), 0);
    chk("mid_rst_full_n", int'(if_full_n), 1);
    chk("mid_rst_occ_max", int'(occ_max), 0);
    step(1'b0, 1'b1, 4'd0, 2'b11, 1'b1, 1'b0, "empty_reads");
    chk("empty_reads_empty_n", int'(if_empty_n), 0);

`ifdef KERNEL_BC_START_FORK_PEAK_EN
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 4'(i), 2'b00, 1'b1, 1'b0, "peak_fill");
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 4'd0, 2'b11, 1'b1, 1'b0, "peak_drain");
    chk("peak_after_drain", int'(peak_occ), 4);
    step(1'b0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b1, "peak_clr");
    chk("peak_cleared", int'(peak_occ), 0);
    step(1'b1, 1'b1, 4'd1, 2'b00, 1'b1, 1'b1, "peak_clr_wins");
    chk("peak_clr_wins", int'(peak_occ), 0);
    step(1'b0, 1'b1, 4'd0, 2'b00, 1'b1, 1'b0, "peak_regrow");
    chk("peak_regrow", int'(peak_occ), 1);
`endif

    // Randomised traffic against the queue model.
    do_reset(1'b0);
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset(1'($urandom_range(0, 1)));
        check_model("rand_rst");
      end else begin
        step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) != 0),
             4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
             1'($urandom_range(0, 7) != 0), 1'($urandom_range(0, 29) == 0), "rand");
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
